// File: rtl/stack_pkg.sv
// Shared defaults and the strobe-decode enum for the operand stack.
package stack_pkg;

  localparam int STK_WIDTH = 8;
  localparam int STK_DEPTH = 16;

  typedef enum logic [2:0] {
    STK_NOP,
    STK_PUSH,
    STK_POP,
    STK_TOS,
    STK_REPL
  } stk_op_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, asynchronous read, no reset on contents.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: owns the stack pointer, registered top-of-stack output,
// strobe decode and sticky overflow/underflow flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = STK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  // Strobes are single-cycle commands with no handshake: each asserted
  // strobe is acted on at the next rising edge, and dout is valid the cycle after.

  logic [PTR_W:0]   sp, sp_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             set_ovf, set_unf;
  logic             we;
  logic [PTR_W-1:0] waddr, raddr;
  logic [WIDTH-1:0] top;
  stk_op_e          op;

  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == (PTR_W+1)'(DEPTH));

  // Low bits of sp minus one addresses the top entry, including sp==DEPTH.
  assign raddr = sp[PTR_W-1:0] - PTR_W'(1);

  stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (top)
  );

  always_comb begin
    op = STK_NOP;
    if (push && pop)  op = STK_REPL;
    else if (pop)     op = STK_POP;
    else if (push)    op = STK_PUSH;
    else if (tos)     op = STK_TOS;
  end

  always_comb begin
    we       = 1'b0;
    waddr    = sp[PTR_W-1:0];
    sp_nxt   = sp;
    dout_nxt = dout;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    case (op)
      STK_REPL: begin
        we = 1'b1;
        if (empty) begin
          sp_nxt  = sp + 1'b1;
          set_unf = 1'b1;
        end else begin
          waddr    = raddr;
          dout_nxt = top;
        end
      end
      STK_PUSH: begin
        // push+tos snapshots the pre-push top before the push lands.
        if (tos) begin
          if (empty) set_unf = 1'b1;
          else       dout_nxt = top;
        end
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          we     = 1'b1;
          sp_nxt = sp + 1'b1;
        end
      end
      STK_POP: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          dout_nxt = top;
          sp_nxt   = sp - 1'b1;
        end
      end
      STK_TOS: begin
        if (empty) set_unf = 1'b1;
        else       dout_nxt = top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp   <= '0;
      dout <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      sp   <= sp_nxt;
      dout <= dout_nxt;
      ovf  <= set_ovf | (ovf & ~clr_err);
      unf  <= set_unf | (unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: expected dout values queued at stimulus time.
module tb_stack_unit;
  import stack_pkg::*;

  localparam int W = STK_WIDTH;
  localparam int D = STK_DEPTH;
  localparam int PW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0, pop = 1'b0, tos = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic [PW:0]   count;
  logic          empty, full, ovf, unf;

  logic [W-1:0]  exp_q [$];
  int            n_cmp = 0;
  int            n_mis = 0;

  stack_unit dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .clr_err(clr_err), .dout(dout), .count(count), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dout(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected <queue empty>", tag, dout);
    end else begin
      check(tag, 32'(dout), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic e_ovf, input logic e_unf);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, ".full"},  32'(full),  32'(cnt == D));
    check({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    check({tag, ".unf"},   32'(unf),   32'(e_unf));
  endtask

  // Drive one cycle of strobes; returns #1 after the sampling edge.
  task automatic step(input logic p, input logic q, input logic t, input logic [W-1:0] d, input logic c);
    push = p; pop = q; tos = t; din = d; clr_err = c;
    @(posedge clk);
    #1;
    push = 0; pop = 0; tos = 0; clr_err = 0;
  endtask

  task automatic do_push(input logic [W-1:0] d);
    step(1, 0, 0, d, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.dout", 32'(dout), 32'h00);
    chk_state("rst", 0, 0, 0);

    // Basic push / tos / pop
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    chk_state("push3", 3, 0, 0);
    exp_q.push_back(8'h33); step(0, 0, 1, '0, 0);
    chk_dout("tos"); chk_state("tos", 3, 0, 0);
    exp_q.push_back(8'h33); step(0, 1, 0, '0, 0);
    chk_dout("pop1"); chk_state("pop1", 2, 0, 0);
    exp_q.push_back(8'h22); step(0, 1, 0, '0, 0);
    chk_dout("pop2"); chk_state("pop2", 1, 0, 0);
    exp_q.push_back(8'h11); step(0, 1, 0, '0, 0);
    chk_dout("pop3"); chk_state("pop3", 0, 0, 0);

    // Asynchronous reset mid-sequence, checked between edges
    do_push(8'hA1); do_push(8'hA2); do_push(8'hA3);
    #2;
    rst = 1'b1;
    #1;
    check("arst.dout", 32'(dout), 32'h00);
    chk_state("arst", 0, 0, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_state("arst_rel", 0, 0, 0);

    // Fill to full, overflow push, pop, clear
    for (int i = 0; i < D; i++) do_push(W'(i));
    chk_state("fill", D, 0, 0);
    do_push(8'hAA);
    chk_state("ovf", D, 1, 0);
    exp_q.push_back(8'h0F); step(0, 1, 0, '0, 0);
    chk_dout("pop_after_ovf"); chk_state("pop_after_ovf", D - 1, 1, 0);
    step(0, 0, 0, '0, 1);
    chk_state("clr_ovf", D - 1, 0, 0);

    // Underflow: pop and tos on empty keep dout
    do_reset();
    do_push(8'h5A);
    exp_q.push_back(8'h5A); step(0, 1, 0, '0, 0);
    chk_dout("pop5a");
    exp_q.push_back(8'h5A); step(0, 1, 0, '0, 0);
    chk_dout("pop_empty"); chk_state("pop_empty", 0, 0, 1);
    exp_q.push_back(8'h5A); step(0, 0, 1, '0, 0);
    chk_dout("tos_empty"); chk_state("tos_empty", 0, 0, 1);
    step(0, 1, 0, '0, 1);
    chk_state("clr_vs_unf", 0, 0, 1);
    step(0, 0, 0, '0, 1);
    chk_state("clr_unf", 0, 0, 0);

    // Replace top (push+pop)
    do_push(8'h05); do_push(8'h07);
    exp_q.push_back(8'h07); step(1, 1, 0, 8'h09, 0);
    chk_dout("repl"); chk_state("repl", 2, 0, 0);
    exp_q.push_back(8'h09); step(0, 1, 0, '0, 0);
    chk_dout("repl_pop"); chk_state("repl_pop", 1, 0, 0);
    exp_q.push_back(8'h05); step(0, 1, 0, '0, 0);
    chk_dout("repl_pop2"); chk_state("repl_pop2", 0, 0, 0);

    // push+pop on empty: push happens, unf set, dout held
    exp_q.push_back(8'h05); step(1, 1, 0, 8'h66, 0);
    chk_dout("repl_empty"); chk_state("repl_empty", 1, 0, 1);
    exp_q.push_back(8'h66); step(0, 1, 0, '0, 1);
    chk_dout("repl_empty_pop"); chk_state("repl_empty_pop", 0, 0, 0);

    // push+tos returns pre-push top
    do_push(8'h40);
    exp_q.push_back(8'h40); step(1, 0, 1, 8'h41, 0);
    chk_dout("push_tos"); chk_state("push_tos", 2, 0, 0);
    exp_q.push_back(8'h41); step(0, 1, 0, '0, 0);
    chk_dout("push_tos_pop"); chk_state("push_tos_pop", 1, 0, 0);

    // Idle holds state
    exp_q.push_back(8'h41);
    repeat (3) step(0, 0, 0, 8'hFF, 0);
    chk_dout("idle"); chk_state("idle", 1, 0, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL leftover: observed %0d queued expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
